// File: rtl/mdu_iter.sv
// Iterative WIDTH-generic multiply/divide unit for EX: shift-add multiply and
// restoring radix-2 divide, one step per cycle, with flush cancel and pause request.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 op_i,
  input  logic                 signed_i,
  input  logic                 cancel_i,
  input  logic [WIDTH-1:0]     oprand1_i,
  input  logic [WIDTH-1:0]     oprand2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 success_o,
  output logic                 pauseRequest_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DZERO = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               s1, s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] mul_sum, mul_res;
  logic [WIDTH:0]     rem_sh, rem_nx;
  logic [WIDTH+1:0]   diff;
  logic               qbit;
  logic [WIDTH-1:0]   quo_nx, quo_res, rem_res;

  always_comb begin
    s1 = signed_i & oprand1_i[WIDTH-1];
    s2 = signed_i & oprand2_i[WIDTH-1];
    // Low WIDTH bits of the (WIDTH+1)-bit negation: MIN maps to its unsigned magnitude.
    abs1 = s1 ? ('0 - oprand1_i) : oprand1_i;
    abs2 = s2 ? ('0 - oprand2_i) : oprand2_i;

    mul_sum = acc_q + (mp_q[0] ? mc_q : '0);
    mul_res = neg_lo_q ? ('0 - mul_sum) : mul_sum;

    // mp_q holds the dividend bits still to shift in, then the quotient bits.
    rem_sh  = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, mc_q[WIDTH-1:0]};
    qbit    = ~diff[WIDTH+1];
    rem_nx  = qbit ? diff[WIDTH:0] : rem_sh;
    quo_nx  = {mp_q[WIDTH-2:0], qbit};
    quo_res = neg_lo_q ? ('0 - quo_nx) : quo_nx;
    rem_res = neg_hi_q ? ('0 - rem_nx[WIDTH-1:0]) : rem_nx[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    op1_d    = op1_q;
    mp_d     = mp_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    res_d    = res_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          op_d     = op_i;
          op1_d    = oprand1_i;
          neg_lo_d = s1 ^ s2;
          neg_hi_d = s1;
          cnt_d    = '0;
          acc_d    = '0;
          if (op_i) begin
            mp_d = abs1;
            mc_d = {{WIDTH{1'b0}}, abs2};
          end else begin
            mp_d = abs2;
            mc_d = {{WIDTH{1'b0}}, abs1};
          end
          state_d = (op_i && (oprand2_i == '0)) ? ST_DZERO : ST_RUN;
        end
      end
      ST_RUN: begin
        if (op_q) begin
          acc_d = (2*WIDTH)'(rem_nx);
          mp_d  = quo_nx;
        end else begin
          acc_d = mul_sum;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = op_q ? {rem_res, quo_res} : mul_res;
          state_d = ST_DONE;
        end
      end
      ST_DZERO: begin
        res_d   = {op1_q, {WIDTH{1'b1}}};
        state_d = ST_DONE;
      end
      default: begin
        if (!start_i) state_d = ST_IDLE;
      end
    endcase

    if (cancel_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      op1_q    <= '0;
      mp_q     <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      op1_q    <= op1_d;
      mp_q     <= mp_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end

  assign result_o       = res_q;
  assign success_o      = (state_q == ST_DONE);
  assign busy_o         = (state_q != ST_IDLE);
  assign pauseRequest_o = ~rst & start_i & ~success_o & ~cancel_i;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit for the EX stage. It replaces the fixed 32-bit single-op divider handshake with one WIDTH-generic engine for signed/unsigned multiply and divide. It sits beside EX: EX drives operands and `start_i`, and the unit returns a 2·WIDTH `{HI,LO}` result with `success_o`. It also drives the pipeline pause request and supports cancellation on flush.

## Interface
- `WIDTH`, default 32: operand width; legal range ≥ 2. Result is 2·WIDTH.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_i`  input  1  request; held high by EX until `success_o` is seen.
- `op_i`  input  1  0 = multiply, 1 = divide.
- `signed_i`  input  1  1 = two's-complement operands.
- `cancel_i`  input  1  flush; aborts any operation in progress.
- `oprand1_i`  input  WIDTH  multiplicand / dividend.
- `oprand2_i`  input  WIDTH  multiplier / divisor.
- `result_o`  output  2·WIDTH  multiply: full product. Divide: {remainder, quotient}.
- `success_o`  output  1  result valid.
- `pauseRequest_o`  output  1  stall request to pipeline control.
- `busy_o`  output  1  state ≠ IDLE.

## Operation
- States are IDLE, RUN, DZERO and DONE.
- IDLE:
  - On `start_i` = 1 and `cancel_i` = 0, latch `op_i`, `signed_i` and the absolute values of both operands (when signed).
  - Also latch the result-sign flags:
    - product/quotient negative = sign1 XOR sign2;
    - remainder negative = sign1.
  - Divide with divisor == 0 goes to DZERO. Otherwise go to RUN with counter = 0.
- RUN performs one step per cycle for exactly WIDTH cycles, then goes to DONE.
  - Multiply: shift-add, LSB of multiplier first. 2·WIDTH accumulator.
  - Divide: restoring radix-2, MSB first.
    - Partial remainder is WIDTH+1 bits.
    - Subtract divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
- Leaving RUN applies the sign correction (two's-complement negate) to the magnitude result.
- DZERO (one cycle) goes to DONE with `result_o` = {oprand1 as latched (original, not abs), all-ones}.
- DONE:
  - `success_o` = 1 and `result_o` stays stable.
  - Remain in DONE while `start_i` = 1; go to IDLE the cycle after `start_i` is sampled 0.
- `cancel_i` = 1 in RUN, DZERO or DONE forces IDLE on the next edge. `success_o` drops and `result_o` is cleared. Cancel has priority over every other transition.
- `pauseRequest_o` = `start_i` AND NOT `success_o` AND NOT `cancel_i` (combinational). It is forced 0 while `rst` = 1.
- Signed most-negative operand (e.g. 0x8000_0000 for WIDTH=32):
  - its abs value is taken in WIDTH+1-bit arithmetic;
  - the quotient of MIN / −1 wraps to MIN;
  - the remainder is 0.
- Operand changes while busy are ignored; only latched values are used.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `result_o` = 0, `success_o` = 0, `busy_o` = 0, `pauseRequest_o` = 0.
- Reset asserted mid-operation discards everything; no `success_o` after release until a new start.
- Normal latency: `start_i` sampled at edge 0 → RUN from edge 0 to edge WIDTH → `success_o` high after edge WIDTH+1. That is 33 cycles for WIDTH = 32.
- Divide-by-zero latency: `success_o` high after edge 2.
- `success_o` stays high for ≥ 1 cycle and until `start_i` goes low.
- A new `start_i` is accepted only from IDLE, so back-to-back operations need one IDLE cycle between them.
- `busy_o` is high from the edge after start through the last DONE cycle.

## Test plan
- **Unsigned divide:** WIDTH=32, divide, unsigned, 100 / 7.
  - `success_o` rises 33 cycles after start.
  - `result_o` = {0x00000002, 0x0000000E}.
  - `pauseRequest_o` is high for exactly those 33 cycles.
- **Signed divide:** −7 / 2.
  - `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}.
  - MIN / −1 gives {0x00000000, 0x80000000}.
- **Signed multiply:** −3 × 5 gives 0xFFFFFFFF_FFFFFFF1. Unsigned 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE_00000001.
- **Divide by zero:** 0x1234 / 0.
  - `success_o` rises after 2 edges.
  - `result_o` = {0x00001234, 0xFFFFFFFF}.
  - Unit holds DONE while `start_i` stays high, then returns to IDLE one cycle after `start_i` drops.
- **Cancel and reset:**
  - `cancel_i` pulsed in RUN cycle 10 → IDLE next cycle, `success_o` never asserted, a new start then completes correctly.
  - `rst` pulsed asynchronously mid-RUN → all outputs 0 immediately.
- **WIDTH = 8 instance:**
  - Signed −128 × −1 gives 0x0080.
  - 200 / 3 unsigned gives {0x02, 0x42}, `success_o` after 9 cycles.
  - Random 1000-op comparison against a behavioural model.
